// File: rtl/fu_result_arbiter_pkg.sv
// Shared constants, result record and small index helpers for the FU result
// arbiter and its per-FU queues.
package fu_result_arbiter_pkg;

    localparam int NUM_FU = 4;
    localparam int DEPTH  = 2;
    localparam int XLEN   = 32;
    localparam int RD_W   = 5;

    localparam int FU_W   = $clog2(NUM_FU);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam int FU_ALU_ID = 0;
    localparam int FU_MEM_ID = 1;
    localparam int FU_MUL_ID = 2;
    localparam int FU_DIV_ID = 3;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [RD_W-1:0] rd;
        logic            ovf;
    } fu_result_t;

    function automatic logic [FU_W-1:0] next_fu(input logic [FU_W-1:0] idx);
        return (idx == FU_W'(NUM_FU - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// One functional unit's result queue: circular buffer of DEPTH entries with
// a registered full flag and a report of pushes rejected at full.
module fu_result_fifo
    import fu_result_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  fu_result_t i_data,
    output fu_result_t o_head,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_drop
);

    fu_result_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_full;

    logic             w_do_pop;
    logic             w_do_push;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full queue still accepts a result when its head leaves in the same cycle.
    assign w_do_push = i_push && (!r_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_do_pop) begin
                r_head <= next_ptr(r_head);
            end
            if (w_do_push) begin
                r_tail <= next_ptr(r_tail);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_tail] <= i_data;
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_empty = (r_count == '0);
    assign o_full  = r_full;

endmodule

// File: rtl/fu_result_arbiter.sv
// Buffers functional-unit results per FU and serialises them onto the single
// write-back bus, one per cycle, with round-robin arbitration across FUs.
module fu_result_arbiter
    import fu_result_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_FU-1:0]      fu_fin,
    input  logic [NUM_FU*XLEN-1:0] fu_res,
    input  logic [NUM_FU*RD_W-1:0] fu_rd,
    input  logic [NUM_FU-1:0]      fu_ovf,
    output logic [NUM_FU-1:0]      q_full,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [FU_W-1:0]        wb_fu,
    output logic [XLEN-1:0]        wb_res,
    output logic [RD_W-1:0]        wb_rd,
    output logic                   wb_ovf,
    output logic                   drop_err
);

    logic [FU_W-1:0]   r_rr_ptr;
    logic              r_drop_err;

    fu_result_t        w_head [NUM_FU];
    logic [NUM_FU-1:0] w_empty;
    logic [NUM_FU-1:0] w_full;
    logic [NUM_FU-1:0] w_drop;
    logic [NUM_FU-1:0] w_pop;
    logic [FU_W-1:0]   w_grant;
    logic              w_fire;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        fu_result_t w_in;
        assign w_in     = '{res: fu_res[i*XLEN +: XLEN], rd: fu_rd[i*RD_W +: RD_W], ovf: fu_ovf[i]};
        assign w_pop[i] = w_fire && (w_grant == FU_W'(i));

        fu_result_fifo u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (fu_fin[i]),
            .i_pop   (w_pop[i]),
            .i_data  (w_in),
            .o_head  (w_head[i]),
            .o_empty (w_empty[i]),
            .o_full  (w_full[i]),
            .o_drop  (w_drop[i])
        );
    end

    always_comb begin
        logic [FU_W-1:0] v_idx;
        logic            v_found;
        w_grant = r_rr_ptr;
        v_idx   = r_rr_ptr;
        v_found = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!v_found && !w_empty[v_idx]) begin
                w_grant = v_idx;
                v_found = 1'b1;
            end
            v_idx = next_fu(v_idx);
        end
    end

    assign wb_valid = ~&w_empty;
    assign w_fire   = wb_valid && wb_ready;

    always_comb begin
        wb_fu  = '0;
        wb_res = '0;
        wb_rd  = '0;
        wb_ovf = 1'b0;
        if (wb_valid) begin
            wb_fu  = w_grant;
            wb_res = w_head[w_grant].res;
            wb_rd  = w_head[w_grant].rd;
            wb_ovf = w_head[w_grant].ovf;
        end
    end

    // While stalled the search restarts at the presented FU, so a result
    // arriving at an earlier-priority queue cannot displace it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_fire) begin
                r_rr_ptr <= next_fu(w_grant);
            end else if (wb_valid) begin
                r_rr_ptr <= w_grant;
            end
            r_drop_err <= r_drop_err | (|w_drop);
        end
    end

    assign q_full   = w_full;
    assign drop_err = r_drop_err;

endmodule

// File: tb/tb_fu_result_arbiter.sv
// Bench for fu_result_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_fu_result_arbiter;
    import fu_result_arbiter_pkg::*;

    localparam int ENT_W = XLEN + RD_W + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_FU-1:0]      fu_fin;
    logic [NUM_FU*XLEN-1:0] fu_res;
    logic [NUM_FU*RD_W-1:0] fu_rd;
    logic [NUM_FU-1:0]      fu_ovf;
    logic [NUM_FU-1:0]      q_full;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [FU_W-1:0]        wb_fu;
    logic [XLEN-1:0]        wb_res;
    logic [RD_W-1:0]        wb_rd;
    logic                   wb_ovf;
    logic                   drop_err;

    fu_result_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .fu_fin   (fu_fin),
        .fu_res   (fu_res),
        .fu_rd    (fu_rd),
        .fu_ovf   (fu_ovf),
        .q_full   (q_full),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_fu    (wb_fu),
        .wb_res   (wb_res),
        .wb_rd    (wb_rd),
        .wb_ovf   (wb_ovf),
        .drop_err (drop_err)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard / reference model state
    typedef logic [ENT_W-1:0] ent_q_t[$];
    ent_q_t exp_q [NUM_FU];
    int     m_rr;
    bit     m_drop;
    bit     m_held;
    int     m_held_fu;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_valid();
        for (int k = 0; k < NUM_FU; k++) begin
            if (exp_q[k].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Round-robin from m_rr, except a stalled result stays presented.
    function automatic int model_grant();
        if (m_held) return m_held_fu;
        for (int k = 0; k < NUM_FU; k++) begin
            int f;
            f = (m_rr + k) % NUM_FU;
            if (exp_q[f].size() != 0) return f;
        end
        return 0;
    endfunction

    task automatic model_step();
        bit v;
        int g;
        bit pop;
        if (rst) begin
            for (int k = 0; k < NUM_FU; k++) exp_q[k].delete();
            m_rr   = 0;
            m_drop = 1'b0;
            m_held = 1'b0;
        end else begin
            v   = model_valid();
            g   = model_grant();
            pop = v && wb_ready;
            if (pop) void'(exp_q[g].pop_front());
            for (int k = 0; k < NUM_FU; k++) begin
                if (fu_fin[k]) begin
                    if (exp_q[k].size() < DEPTH)
                        exp_q[k].push_back({fu_res[k*XLEN +: XLEN], fu_rd[k*RD_W +: RD_W], fu_ovf[k]});
                    else
                        m_drop = 1'b1;
                end
            end
            if (pop) begin
                m_rr   = (g + 1) % NUM_FU;
                m_held = 1'b0;
            end else if (v) begin
                m_held    = 1'b1;
                m_held_fu = g;
            end else begin
                m_held = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        bit                v;
        int                g;
        logic [ENT_W-1:0]  h;
        logic [NUM_FU-1:0] exp_full;
        v = model_valid();
        g = model_grant();
        h = v ? exp_q[g][0] : '0;
        for (int k = 0; k < NUM_FU; k++) exp_full[k] = (exp_q[k].size() == DEPTH);
        check_val("wb_valid", wb_valid, v);
        check_val("wb_fu", wb_fu, v ? g : 0);
        check_val("wb_res", wb_res, h[ENT_W-1 -: XLEN]);
        check_val("wb_rd", wb_rd, h[RD_W:1]);
        check_val("wb_ovf", wb_ovf, h[0]);
        check_val("q_full", q_full, exp_full);
        check_val("drop_err", drop_err, m_drop);
    endtask

    // driver: apply inputs mid-cycle, advance model, check after the edge
    task automatic drive_cycle(input bit r, input logic [NUM_FU-1:0] fin,
                               input logic [NUM_FU*XLEN-1:0] res, input logic [NUM_FU*RD_W-1:0] rd,
                               input logic [NUM_FU-1:0] ovf, input bit rdy);
        rst      = r;
        fu_fin   = fin;
        fu_res   = res;
        fu_rd    = rd;
        fu_ovf   = ovf;
        wb_ready = rdy;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic one_fu(input int f, input logic [XLEN-1:0] v, input logic [RD_W-1:0] d, input bit rdy);
        logic [NUM_FU*XLEN-1:0] res;
        logic [NUM_FU*RD_W-1:0] rd;
        logic [NUM_FU-1:0]      fin;
        res = '0;
        rd  = '0;
        fin = '0;
        res[f*XLEN +: XLEN] = v;
        rd[f*RD_W +: RD_W]  = d;
        fin[f]              = 1'b1;
        drive_cycle(1'b0, fin, res, rd, '0, rdy);
    endtask

    task automatic idle(input bit rdy);
        drive_cycle(1'b0, '0, '0, '0, '0, rdy);
    endtask

    task automatic reset_cycle();
        drive_cycle(1'b1, '0, '0, '0, '0, 1'b1);
    endtask

    initial begin
        bit seen;
        rst      = 1'b1;
        fu_fin   = '0;
        fu_res   = '0;
        fu_rd    = '0;
        fu_ovf   = '0;
        wb_ready = 1'b0;
        @(negedge clk);

        // reset state
        reset_cycle();
        check_val("rst_valid", wb_valid, 0);
        check_val("rst_qfull", q_full, 0);

        // single ALU result
        one_fu(FU_ALU_ID, 32'h5, 5'd3, 1'b1);
        check_val("s1_valid", wb_valid, 1);
        check_val("s1_fu", wb_fu, FU_ALU_ID);
        check_val("s1_res", wb_res, 32'h5);
        check_val("s1_rd", wb_rd, 3);
        idle(1'b1);
        check_val("s1_idle_valid", wb_valid, 0);
        check_val("s1_idle_res", wb_res, 0);

        // simultaneous finish from all FUs
        reset_cycle();
        drive_cycle(1'b0, 4'hf, {32'h40, 32'h30, 32'h20, 32'h10}, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b1000, 1'b1);
        for (int k = 0; k < NUM_FU; k++) begin
            check_val("sim_res", wb_res, (k + 1) * 16);
            idle(1'b1);
        end
        check_val("sim_drained", wb_valid, 0);
        drive_cycle(1'b0, 4'b1001, {32'h93, 32'h0, 32'h0, 32'h90}, '0, '0, 1'b1);
        check_val("sim_rr_back_to_0", wb_fu, FU_ALU_ID);
        idle(1'b1);
        idle(1'b1);

        // backpressure on MEM queue
        reset_cycle();
        one_fu(FU_MEM_ID, 32'hA, 5'd1, 1'b0);
        one_fu(FU_MEM_ID, 32'hB, 5'd2, 1'b0);
        check_val("bp_full", q_full[FU_MEM_ID], 1);
        check_val("bp_stuck", wb_res, 32'hA);
        one_fu(FU_MEM_ID, 32'hC, 5'd3, 1'b0);
        check_val("bp_drop", drop_err, 1);
        check_val("bp_still_a", wb_res, 32'hA);
        idle(1'b1);
        check_val("bp_then_b", wb_res, 32'hB);
        idle(1'b1);
        check_val("bp_empty", wb_valid, 0);

        // full MUL queue accepting a push alongside a pop
        reset_cycle();
        one_fu(FU_MUL_ID, 32'h61, 5'd1, 1'b0);
        one_fu(FU_MUL_ID, 32'h62, 5'd2, 1'b0);
        check_val("pp_full_before", q_full[FU_MUL_ID], 1);
        one_fu(FU_MUL_ID, 32'h77, 5'd7, 1'b1);
        check_val("pp_full_after", q_full[FU_MUL_ID], 1);
        check_val("pp_no_drop", drop_err, 0);
        check_val("pp_head", wb_res, 32'h62);
        idle(1'b1);
        check_val("pp_new", wb_res, 32'h77);
        idle(1'b1);

        // fairness: ALU fires every cycle, DIV has one result
        reset_cycle();
        seen = 1'b0;
        drive_cycle(1'b0, 4'b1001, {32'hD0, 32'h0, 32'h0, 32'h100}, '0, '0, 1'b1);
        for (int k = 0; k < NUM_FU; k++) begin
            if (wb_valid && wb_fu == FU_W'(FU_DIV_ID)) seen = 1'b1;
            one_fu(FU_ALU_ID, 32'h101 + k, 5'd0, 1'b1);
        end
        check_val("fair_div_granted", seen, 1);

        // mid-operation reset
        reset_cycle();
        drive_cycle(1'b0, 4'b0111, {32'h0, 32'h3, 32'h2, 32'h1}, '0, '0, 1'b0);
        drive_cycle(1'b0, 4'b0111, {32'h0, 32'h6, 32'h5, 32'h4}, '0, '0, 1'b0);
        drive_cycle(1'b1, 4'hf, {32'hE, 32'hE, 32'hE, 32'hE}, '0, '0, 1'b1);
        check_val("mr_valid", wb_valid, 0);
        check_val("mr_qfull", q_full, 0);
        for (int k = 0; k < 3; k++) idle(1'b1);
        check_val("mr_no_stale", wb_valid, 0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [NUM_FU-1:0]      fin;
            logic [NUM_FU*XLEN-1:0] res;
            logic [NUM_FU*RD_W-1:0] rd;
            for (int k = 0; k < NUM_FU; k++) begin
                fin[k]              = ($urandom_range(0, 99) < 40);
                res[k*XLEN +: XLEN] = $urandom;
                rd[k*RD_W +: RD_W]  = RD_W'($urandom);
            end
            drive_cycle($urandom_range(0, 99) < 2, fin, res, rd, NUM_FU'($urandom),
                        $urandom_range(0, 99) < 70);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
